// File: rtl/dsp_wdata_router.sv
// Write-data router: queues AW routing decisions and steers W bursts to slave ports in AW order.
// Optional master-WLAST mismatch flag enabled by defining DSP_WDATA_WLAST_CHECK_EN.
module dsp_wdata_router #(
    parameter int SLV_AMT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int SLV_ID_W   = $clog2(SLV_AMT),
    parameter int LEN_W      = 8,
    parameter int OST_DEPTH  = 4
) (
    input  logic                           ACLK_i,
    input  logic                           ARESETn_i,
    input  logic [DATA_WIDTH-1:0]          m_WDATA_i,
    input  logic [STRB_WIDTH-1:0]          m_WSTRB_i,
    input  logic                           m_WLAST_i,
    input  logic                           m_WVALID_i,
    output logic                           m_WREADY_o,
    input  logic [SLV_ID_W-1:0]            dsp_AW_slv_id_i,
    input  logic [LEN_W-1:0]               dsp_AW_len_i,
    input  logic                           dsp_AW_valid_i,
    output logic                           dsp_AW_ready_o,
    output logic [DATA_WIDTH*SLV_AMT-1:0]  sa_WDATA_o,
    output logic [STRB_WIDTH*SLV_AMT-1:0]  sa_WSTRB_o,
    output logic [SLV_AMT-1:0]             sa_WLAST_o,
    output logic [SLV_AMT-1:0]             sa_WVALID_o,
    input  logic [SLV_AMT-1:0]             sa_WREADY_i,
    output logic [$clog2(OST_DEPTH+1)-1:0] ost_cnt_o,
    output logic                           wlast_err_o
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = $clog2(OST_DEPTH + 1);
    localparam int Q_W   = SLV_ID_W + LEN_W;

    logic [Q_W-1:0]        mem_q [OST_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      beat_q, beat_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  last_q, last_d;
    logic [SLV_ID_W-1:0]   sel_q, sel_d;
    logic                  vld_q, vld_d;

    logic                  full, empty, push, pop;
    logic                  in_fire, out_fire, is_last;
    logic [SLV_ID_W-1:0]   h_id;
    logic [LEN_W-1:0]      h_len;

    assign full           = (cnt_q == CNT_W'(OST_DEPTH));
    assign empty          = (cnt_q == '0);
    assign {h_id, h_len}  = mem_q[rd_ptr_q];
    assign is_last        = (beat_q == h_len);
    assign dsp_AW_ready_o = ~full;
    assign push           = dsp_AW_valid_i & ~full;
    assign out_fire       = vld_q & sa_WREADY_i[sel_q];
    assign m_WREADY_o     = ~empty & (~vld_q | out_fire);
    assign in_fire        = m_WVALID_i & m_WREADY_o;
    assign pop            = in_fire & is_last;
    assign ost_cnt_o      = cnt_q;

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dsp_AW_slv_id_i, dsp_AW_len_i};
        end
    end

    // Queue bookkeeping, beat counter and the single output stage register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        data_d   = data_q;
        strb_d   = strb_q;
        last_d   = last_q;
        sel_d    = sel_q;
        vld_d    = vld_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (in_fire) begin
            data_d = m_WDATA_i;
            strb_d = m_WSTRB_i;
            last_d = is_last;
            sel_d  = h_id;
            vld_d  = 1'b1;
            beat_d = is_last ? '0 : beat_q + LEN_W'(1);
        end else if (out_fire) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            last_q   <= 1'b0;
            sel_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            vld_q    <= vld_d;
        end
    end

    assign sa_WDATA_o = {SLV_AMT{data_q}};
    assign sa_WSTRB_o = {SLV_AMT{strb_q}};
    assign sa_WLAST_o = {SLV_AMT{last_q}};

    for (genvar i = 0; i < SLV_AMT; i++) begin : g_valid
        assign sa_WVALID_o[i] = vld_q & (sel_q == SLV_ID_W'(i));
    end

`ifdef DSP_WDATA_WLAST_CHECK_EN
    logic err_q;

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= in_fire & (m_WLAST_i != is_last);
        end
    end

    assign wlast_err_o = err_q;
`else
    logic unused_wlast;

    assign unused_wlast = m_WLAST_i;
    assign wlast_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_wdata_router.sv
// Directed testbench for dsp_wdata_router: routing order, WLAST regeneration, back-pressure,
// queue fill, reset mid-burst and the optional WLAST mismatch flag.
module tb_dsp_wdata_router;

    localparam int SLV_AMT    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;
    localparam int SLV_ID_W   = 2;
    localparam int LEN_W      = 8;
    localparam int OST_DEPTH  = 4;

    logic                          clk;
    logic                          rstN;
    logic [DATA_WIDTH-1:0]         mWdata;
    logic [STRB_WIDTH-1:0]         mWstrb;
    logic                          mWlast;
    logic                          mWvalid;
    logic                          mWready;
    logic [SLV_ID_W-1:0]           awId;
    logic [LEN_W-1:0]              awLen;
    logic                          awValid;
    logic                          awReady;
    logic [DATA_WIDTH*SLV_AMT-1:0] saWdata;
    logic [STRB_WIDTH*SLV_AMT-1:0] saWstrb;
    logic [SLV_AMT-1:0]            saWlast;
    logic [SLV_AMT-1:0]            saWvalid;
    logic [SLV_AMT-1:0]            saWready;
    logic [2:0]                    ostCnt;
    logic                          wlastErr;

    int nVectors     = 0;
    int nMiscompares = 0;
    logic expErr;

    dsp_wdata_router #(
        .SLV_AMT(SLV_AMT), .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH),
        .SLV_ID_W(SLV_ID_W), .LEN_W(LEN_W), .OST_DEPTH(OST_DEPTH)
    ) dut (
        .ACLK_i(clk), .ARESETn_i(rstN),
        .m_WDATA_i(mWdata), .m_WSTRB_i(mWstrb), .m_WLAST_i(mWlast),
        .m_WVALID_i(mWvalid), .m_WREADY_o(mWready),
        .dsp_AW_slv_id_i(awId), .dsp_AW_len_i(awLen),
        .dsp_AW_valid_i(awValid), .dsp_AW_ready_o(awReady),
        .sa_WDATA_o(saWdata), .sa_WSTRB_o(saWstrb), .sa_WLAST_o(saWlast),
        .sa_WVALID_o(saWvalid), .sa_WREADY_i(saWready),
        .ost_cnt_o(ostCnt), .wlast_err_o(wlastErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] s, input logic l);
        mWdata  = d;
        mWstrb  = s;
        mWlast  = l;
        mWvalid = 1'b1;
        #1;
    endtask

    task automatic pushAw(input logic [1:0] id, input logic [7:0] len);
        awId    = id;
        awLen   = len;
        awValid = 1'b1;
        tick();
        awValid = 1'b0;
    endtask

    task automatic checkBeat(input string tag, input logic [3:0] v, input logic [31:0] d,
                             input logic [3:0] s, input logic l);
        checkOutput({tag, " valid"}, 128'(saWvalid), 128'(v));
        checkOutput({tag, " data"}, 128'(saWdata), {4{d}});
        checkOutput({tag, " strb"}, 128'(saWstrb), 128'({4{s}}));
        checkOutput({tag, " last"}, 128'(saWlast), 128'({4{l}}));
    endtask

    initial begin
        rstN = 1'b0; mWdata = '0; mWstrb = '0; mWlast = 1'b0; mWvalid = 1'b0;
        awId = '0; awLen = '0; awValid = 1'b0; saWready = 4'b1111;

        // Reset values after two cycles of reset
        tick(); tick();
        rstN = 1'b1;
        #1;
        checkOutput("rst wready", 128'(mWready), 128'(0));
        checkOutput("rst awready", 128'(awReady), 128'(1));
        checkOutput("rst ost", 128'(ostCnt), 128'(0));
        checkOutput("rst err", 128'(wlastErr), 128'(0));
        checkBeat("rst", 4'b0000, 32'h0, 4'h0, 1'b0);

        // W before any AW is blocked
        applyStimulus(32'hDEAD0000, 4'hF, 1'b0);
        checkOutput("noaw wready", 128'(mWready), 128'(0));
        tick();
        checkOutput("noaw valid", 128'(saWvalid), 128'(0));
        mWvalid = 1'b0;

        // Single burst id=2 len=3
        pushAw(2'd2, 8'd3);
        checkOutput("t2 ost", 128'(ostCnt), 128'(1));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'hC0DE0000 + 32'(k), 4'hF - 4'(k), k == 3);
            checkOutput("t2 wready", 128'(mWready), 128'(1));
            tick();
            checkBeat("t2 beat", 4'b0100, 32'hC0DE0000 + 32'(k), 4'hF - 4'(k), k == 3);
        end
        mWvalid = 1'b0;
        #1;
        checkOutput("t2 ost end", 128'(ostCnt), 128'(0));
        checkOutput("t2 wready end", 128'(mWready), 128'(0));
        tick();
        checkOutput("t2 idle", 128'(saWvalid), 128'(0));

        // Reset in the middle of a burst
        pushAw(2'd0, 8'd3);
        applyStimulus(32'h11110000, 4'hF, 1'b0);
        tick();
        checkOutput("mr beat", 128'(saWvalid), 128'(4'b0001));
        rstN = 1'b0;
        tick();
        checkOutput("mr valid", 128'(saWvalid), 128'(0));
        checkOutput("mr ost", 128'(ostCnt), 128'(0));
        checkOutput("mr wready", 128'(mWready), 128'(0));
        rstN = 1'b1;
        mWvalid = 1'b0;
        tick();
        checkOutput("mr after valid", 128'(saWvalid), 128'(0));
        checkOutput("mr after data", 128'(saWdata), 128'(0));

        // Three queued bursts streamed without bubbles
        pushAw(2'd1, 8'd0);
        pushAw(2'd3, 8'd1);
        pushAw(2'd0, 8'd0);
        checkOutput("t3 ost", 128'(ostCnt), 128'(3));
        begin
            logic [3:0] vExp [4];
            logic       lExp [4];
            vExp = '{4'b0010, 4'b1000, 4'b1000, 4'b0001};
            lExp = '{1'b1, 1'b0, 1'b1, 1'b1};
            for (int k = 0; k < 4; k++) begin
                applyStimulus(32'hB0000000 + 32'(k), 4'h5, lExp[k]);
                checkOutput("t3 wready", 128'(mWready), 128'(1));
                tick();
                checkBeat("t3 beat", vExp[k], 32'hB0000000 + 32'(k), 4'h5, lExp[k]);
            end
        end
        mWvalid = 1'b0;
        #1;
        checkOutput("t3 ost end", 128'(ostCnt), 128'(0));
        tick();

        // Back-pressure from slave 2 for three cycles mid-burst
        pushAw(2'd2, 8'd3);
        applyStimulus(32'hA0000000, 4'hF, 1'b0);
        tick();
        applyStimulus(32'hA0000001, 4'hF, 1'b0);
        tick();
        checkBeat("bp pre", 4'b0100, 32'hA0000001, 4'hF, 1'b0);
        applyStimulus(32'hA0000002, 4'hF, 1'b0);
        saWready = 4'b1011;
        #1;
        checkOutput("bp wready", 128'(mWready), 128'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            checkBeat("bp hold", 4'b0100, 32'hA0000001, 4'hF, 1'b0);
            checkOutput("bp stall wready", 128'(mWready), 128'(0));
        end
        saWready = 4'b1111;
        #1;
        checkOutput("bp resume wready", 128'(mWready), 128'(1));
        tick();
        checkBeat("bp b2", 4'b0100, 32'hA0000002, 4'hF, 1'b0);
        applyStimulus(32'hA0000003, 4'hF, 1'b1);
        tick();
        checkBeat("bp b3", 4'b0100, 32'hA0000003, 4'hF, 1'b1);
        mWvalid = 1'b0;
        tick();
        checkOutput("bp idle", 128'(saWvalid), 128'(0));
        checkOutput("bp ost", 128'(ostCnt), 128'(0));

        // Fill the routing queue, then free one slot
        pushAw(2'd0, 8'd0);
        pushAw(2'd1, 8'd0);
        pushAw(2'd2, 8'd0);
        pushAw(2'd3, 8'd0);
        checkOutput("fill ost", 128'(ostCnt), 128'(4));
        checkOutput("fill awready", 128'(awReady), 128'(0));
        awId = 2'd1; awLen = 8'd5; awValid = 1'b1;
        applyStimulus(32'hF0000000, 4'h1, 1'b1);
        checkOutput("fill awready pop", 128'(awReady), 128'(0));
        tick();
        awValid = 1'b0;
        checkOutput("fill awready back", 128'(awReady), 128'(1));
        checkOutput("fill ost pop", 128'(ostCnt), 128'(3));
        checkBeat("fill b0", 4'b0001, 32'hF0000000, 4'h1, 1'b1);
        begin
            logic [3:0] vExp [3];
            vExp = '{4'b0010, 4'b0100, 4'b1000};
            for (int k = 0; k < 3; k++) begin
                applyStimulus(32'hF0000001 + 32'(k), 4'h1, 1'b1);
                tick();
                checkBeat("fill drain", vExp[k], 32'hF0000001 + 32'(k), 4'h1, 1'b1);
            end
        end
        mWvalid = 1'b0;
        tick();
        checkOutput("fill ost end", 128'(ostCnt), 128'(0));

        // Early master WLAST on a two-beat burst
`ifdef DSP_WDATA_WLAST_CHECK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        pushAw(2'd1, 8'd1);
        applyStimulus(32'hE0000000, 4'hF, 1'b1);
        tick();
        checkOutput("wl err pulse", 128'(wlastErr), 128'(expErr));
        checkBeat("wl b0", 4'b0010, 32'hE0000000, 4'hF, 1'b0);
        applyStimulus(32'hE0000001, 4'hF, 1'b1);
        tick();
        checkOutput("wl err clear", 128'(wlastErr), 128'(0));
        checkBeat("wl b1", 4'b0010, 32'hE0000001, 4'hF, 1'b1);
        mWvalid = 1'b0;
        tick();
        checkOutput("wl err idle", 128'(wlastErr), 128'(0));
        checkOutput("wl valid idle", 128'(saWvalid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/dsp_wdata_router.md
# dsp_wdata_router

Write-data dispatcher for the AXI4 interconnect with multiple outstanding writes. It queues up to OST_DEPTH slave decisions (slave ID plus AWLEN) from the AW dispatcher and steers each master W burst to its target slave arbitration port in AW order. It regenerates WLAST from a beat counter, registers the W path with full throughput, and optionally flags master WLAST mismatches. It sits between the master-side W channel and the per-slave W arbitration inputs.

## Interface
- SLV_AMT, 4, number of slave ports
- DATA_WIDTH, 32, W data width
- STRB_WIDTH, DATA_WIDTH/8, WSTRB width
- SLV_ID_W, $clog2(SLV_AMT), slave ID width
- LEN_W, 8, AWLEN width
- OST_DEPTH, 4, routing-queue depth (≥2, power of 2)
- ACLK_i  in  1  clock
- ARESETn_i  in  1  reset; one clock, reset synchronous active-low
- m_WDATA_i  in  DATA_WIDTH  master write data
- m_WSTRB_i  in  STRB_WIDTH  master write strobes
- m_WLAST_i  in  1  master WLAST (checked only, not forwarded)
- m_WVALID_i  in  1  master W valid
- m_WREADY_o  out  1  master W ready
- dsp_AW_slv_id_i  in  SLV_ID_W  target slave of accepted AW
- dsp_AW_len_i  in  LEN_W  AWLEN of accepted AW
- dsp_AW_valid_i  in  1  push request into routing queue
- dsp_AW_ready_o  out  1  routing queue not full
- sa_WDATA_o  out  DATA_WIDTH*SLV_AMT  registered data, broadcast to all slots
- sa_WSTRB_o  out  STRB_WIDTH*SLV_AMT  registered strobes, broadcast
- sa_WLAST_o  out  SLV_AMT  regenerated WLAST, broadcast
- sa_WVALID_o  out  SLV_AMT  one-hot valid, selected slave only
- sa_WREADY_i  in  SLV_AMT  per-slave W ready
- ost_cnt_o  out  $clog2(OST_DEPTH+1)  queued transactions
- wlast_err_o  out  1  one-cycle pulse on WLAST mismatch

## Operation
- Routing queue: synchronous FIFO of {slv_id, len}.
  - Push on dsp_AW_valid_i & dsp_AW_ready_o.
  - dsp_AW_ready_o = ~full. It stays low when full even if a pop occurs in the same cycle.
  - Push and pop in the same cycle (not full, not empty): count unchanged.
  - Pointers wrap modulo OST_DEPTH.
- Head entry {h_id, h_len} is valid only when the queue is non-empty. It is registered, so it becomes visible the cycle after the push.
- Output stage: one register {data, strb, last, sel_id, out_valid}.
  - out_fire = out_valid & sa_WREADY_i[sel_id].
  - m_WREADY_o = ~empty & (~out_valid | out_fire).
- Input accept (in_fire = m_WVALID_i & m_WREADY_o):
  - register loads m_WDATA_i, m_WSTRB_i, last = (beat_cnt == h_len), sel_id = h_id; out_valid ← 1.
- No in_fire and out_fire: out_valid ← 0.
- Beat counter (LEN_W bits):
  - in_fire & ~last: increments.
  - in_fire & last: clears to 0 and pops the queue head.
  - The next burst's first beat can be accepted the following cycle.
- sa_WVALID_o[i] = out_valid & (sel_id == i).
- sa_WDATA_o, sa_WSTRB_o and sa_WLAST_o drive the register contents to every slot.
- The master's WLAST never influences routing or the pop.
- ost_cnt_o is the FIFO occupancy, including the entry whose burst is in progress.

## Timing
- Reset values:
  - m_WREADY_o 0 (queue empty); dsp_AW_ready_o 1
  - sa_WVALID_o 0; sa_WDATA_o, sa_WSTRB_o, sa_WLAST_o 0
  - ost_cnt_o 0; wlast_err_o 0
  - beat counter 0; pointers 0
- Reset mid-burst discards queue contents, the beat count and the output register without emitting further beats.
- AW push to first W acceptance: minimum 1 cycle.
- Master W to slave W: 1-cycle latency.
- Throughput: 1 beat/cycle sustained while the selected slave is ready, including across burst boundaries when the next head is already queued.
- Output register holds stable while out_valid & ~sa_WREADY_i[sel_id] (AXI valid stability).
- Queue empty: m_WREADY_o is 0 even if m_WVALID_i is asserted; W never precedes its AW.

## Configuration
- DSP_WDATA_WLAST_CHECK_EN defined:
  - on every in_fire, wlast_err_o pulses for the following cycle when m_WLAST_i ≠ (beat_cnt == h_len).
  - Routing is unaffected.
- Undefined: wlast_err_o tied 0; m_WLAST_i unused.

## Test plan
- Reset: after ARESETn_i is held low for 2 cycles, every output matches its reset value, including m_WREADY_o=0 and dsp_AW_ready_o=1.
- Push {id=2,len=3}, then 4 back-to-back beats with all slaves ready:
  - sa_WVALID_o=4'b0100 for 4 consecutive cycles starting 1 cycle after the first accept;
  - sa_WLAST_o high on beat 4 only; ost_cnt_o returns 0.
- Push {1,0},{3,1},{0,0}, then stream 4 beats:
  - valids 0010, 1000, 1000, 0001 on consecutive cycles with no bubbles;
  - WLAST high on beats 1, 3 and 4.
- Back-pressure: sa_WREADY_i[2]=0 for 3 cycles mid-burst:
  - data held stable; m_WREADY_o=0 during the stall;
  - no beat lost or duplicated.
- Fill: 4 pushes with no W traffic give dsp_AW_ready_o=0 and ost_cnt_o=4; completing one burst restores ready the next cycle.
- With the macro defined, len=1 and m_WLAST_i=1 on beat 1: wlast_err_o pulses once, and WLAST is still asserted on beat 2.
